// File: rtl/const_div_pkg.sv
// rtl/const_div_pkg.sv - width helpers and parameter legality for the constant divider
package const_div_pkg;

  function automatic int flog2_f(input int n);
    int r;
    int v;
    r = 0;
    v = n;
    while (v > 1) begin
      v = v >> 1;
      r++;
    end
    return r;
  endfunction

  function automatic int qw_f(input int width, input int divisor);
    return width - flog2_f(divisor);
  endfunction

  function automatic int rw_f(input int divisor);
    return $clog2(divisor);
  endfunction

  function automatic int stages_f(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  function automatic bit params_ok_f(input int width, input int divisor, input int chunk);
    return (width >= 8) && (width <= 64) &&
           (divisor >= 2) && (divisor <= 65535) &&
           (chunk >= 1) && (chunk <= 8) &&
           (qw_f(width, divisor) >= 1);
  endfunction

endpackage

// File: rtl/const_div_stage.sv
// rtl/const_div_stage.sv - one combinational long-division step by a constant divisor
module const_div_stage
  import const_div_pkg::*;
#(
  parameter int DIVISOR = 23,
  parameter int CHUNK = 4,
  localparam int RW = rw_f(DIVISOR)
) (
  input  logic [RW-1:0]    r_in,
  input  logic [CHUNK-1:0] v_in,
  output logic [CHUNK-1:0] q_dig,
  output logic [RW-1:0]    r_out
);

  logic [31:0] w_t;

  always_comb begin
    w_t = 32'({r_in, v_in});
    q_dig = '0;
    // r_in < DIVISOR keeps the digit below 2^CHUNK, so a ladder of constant multiples is exact
    for (int k = 1; k < (1 << CHUNK); k++) begin
      if (w_t >= 32'(k * DIVISOR)) q_dig = CHUNK'(k);
    end
    r_out = RW'(w_t - 32'(q_dig) * 32'(DIVISOR));
  end

endmodule

// File: rtl/const_div_pipe.sv
// rtl/const_div_pipe.sv - pipelined divide by constant; CONST_DIV_REM_OUT_EN adds the R_out port
module const_div_pipe
  import const_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIVISOR = 23,
  parameter int CHUNK = 4,
  localparam int QW = qw_f(WIDTH, DIVISOR),
  localparam int RW = rw_f(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] IN_X,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    Q_out
`ifdef CONST_DIV_REM_OUT_EN
  ,
  output logic [RW-1:0]    R_out
`endif
);

  localparam int S = stages_f(WIDTH, CHUNK);
  localparam int PW = S * CHUNK;

  if (!params_ok_f(WIDTH, DIVISOR, CHUNK)) begin : g_param_check
    $error("const_div_pipe: illegal WIDTH/DIVISOR/CHUNK combination");
  end

  // each word holds quotient digits above the chunk being consumed and dividend bits below it
  logic [PW-1:0] r_w [S];
  logic [RW-1:0] r_r [S];
  logic [S-1:0]  r_v;
  logic          r_out_valid;
  logic [QW-1:0] r_q;
  logic [PW-1:0] w_wn [S];
  logic [RW-1:0] w_rn [S];
  logic          w_adv;
  logic          w_unused;

  assign w_adv     = out_ready || !r_out_valid;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign Q_out     = r_q;

  for (genvar i = 0; i < S; i++) begin : g_stage
    localparam int C = S - 1 - i;
    logic [CHUNK-1:0] w_qd;

    const_div_stage #(
      .DIVISOR(DIVISOR),
      .CHUNK  (CHUNK)
    ) u_stage (
      .r_in (r_r[i]),
      .v_in (r_w[i][C*CHUNK +: CHUNK]),
      .q_dig(w_qd),
      .r_out(w_rn[i])
    );

    assign w_wn[i] = (r_w[i] & ~(PW'({CHUNK{1'b1}}) << (C * CHUNK))) | (PW'(w_qd) << (C * CHUNK));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v         <= '0;
      r_out_valid <= 1'b0;
      r_q         <= '0;
      for (int i = 0; i < S; i++) begin
        r_w[i] <= '0;
        r_r[i] <= '0;
      end
    end else if (w_adv) begin
      r_v[0] <= in_valid;
      if (in_valid) r_w[0] <= PW'(IN_X);
      r_r[0] <= '0;
      for (int i = 1; i < S; i++) begin
        r_v[i] <= r_v[i-1];
        if (r_v[i-1]) begin
          r_w[i] <= w_wn[i-1];
          r_r[i] <= w_rn[i-1];
        end
      end
      r_out_valid <= r_v[S-1];
      if (r_v[S-1]) r_q <= w_wn[S-1][QW-1:0];
    end
  end

`ifdef CONST_DIV_REM_OUT_EN
  logic [RW-1:0] r_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
    end else if (w_adv && r_v[S-1]) begin
      r_rem <= w_rn[S-1];
    end
  end

  assign R_out    = r_rem;
  // quotient bits above QW are always zero
  assign w_unused = ^w_wn[S-1][PW-1:QW];
`else
  assign w_unused = ^{w_wn[S-1][PW-1:QW], w_rn[S-1]};
`endif

endmodule

// File: tb/tb_const_div_pipe.sv
// tb/tb_const_div_pipe.sv - directed and randomized checks of const_div_pipe
module tb_const_div_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_x;
  logic [27:0] q_out;
  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [23:0] in_x2;
  logic [21:0] q_out2;
`ifdef CONST_DIV_REM_OUT_EN
  logic [4:0]  r_out;
  logic [2:0]  r_out2;
`endif
  logic [4:0]  exp_r_unused;

  int checks = 0;
  int failures = 0;

  const_div_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .IN_X     (in_x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Q_out    (q_out)
`ifdef CONST_DIV_REM_OUT_EN
    ,
    .R_out    (r_out)
`endif
  );

  const_div_pipe #(.WIDTH(24), .DIVISOR(7), .CHUNK(3)) dut7 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .IN_X     (in_x2),
    .out_valid(out_valid2),
    .out_ready(out_ready2),
    .Q_out    (q_out2)
`ifdef CONST_DIV_REM_OUT_EN
    ,
    .R_out    (r_out2)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_x2 = '0; out_ready2 = 1'b1;
    exp_r_unused = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++;
    if (q_out !== 28'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q_out); end
`ifdef CONST_DIV_REM_OUT_EN
    checks++;
    if (r_out !== 5'd0) begin failures++; $display("FAIL reset_r got=%0d exp=0", r_out); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single(input logic [31:0] x, input logic [27:0] eq, input logic [4:0] er, input string name);
    int n;
    in_valid = 1'b1; in_x = x; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (n !== 9) begin failures++; $display("FAIL %s_latency got=%0d exp=9", name, n); end
    checks++;
    if (q_out !== eq) begin failures++; $display("FAIL %s_q got=%0d exp=%0d", name, q_out, eq); end
`ifdef CONST_DIV_REM_OUT_EN
    checks++;
    if (r_out !== er) begin failures++; $display("FAIL %s_r got=%0d exp=%0d", name, r_out, er); end
`else
    exp_r_unused = er;
`endif
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = 32'd23; step();
    in_x = 32'd46; step();
    in_x = 32'd22; step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin step(); n++; end
    checks++;
    if (out_valid !== 1'b1 || q_out !== 28'd1) begin failures++; $display("FAIL b2b_first valid=%0b q=%0d exp q=1", out_valid, q_out); end
`ifdef CONST_DIV_REM_OUT_EN
    checks++;
    if (r_out !== 5'd0) begin failures++; $display("FAIL b2b_first_r got=%0d exp=0", r_out); end
`endif
    step();
    checks++;
    if (out_valid !== 1'b1 || q_out !== 28'd2) begin failures++; $display("FAIL b2b_second valid=%0b q=%0d exp q=2", out_valid, q_out); end
    step();
    checks++;
    if (out_valid !== 1'b1 || q_out !== 28'd0) begin failures++; $display("FAIL b2b_third valid=%0b q=%0d exp q=0", out_valid, q_out); end
`ifdef CONST_DIV_REM_OUT_EN
    checks++;
    if (r_out !== 5'd22) begin failures++; $display("FAIL b2b_third_r got=%0d exp=22", r_out); end
`endif
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_after valid=%0b exp=0", out_valid); end
  endtask

  task automatic test_bubble();
    int n;
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = 32'd230; step();
    in_valid = 1'b0; step();
    in_valid = 1'b1; in_x = 32'd46; step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin step(); n++; end
    checks++;
    if (out_valid !== 1'b1 || q_out !== 28'd10) begin failures++; $display("FAIL bubble_first valid=%0b q=%0d exp q=10", out_valid, q_out); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bubble_gap valid=%0b exp=0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b1 || q_out !== 28'd2) begin failures++; $display("FAIL bubble_second valid=%0b q=%0d exp q=2", out_valid, q_out); end
    step();
  endtask

  task automatic test_stall();
    int vals [10];
    int acc;
    int got;
    for (int k = 0; k < 10; k++) vals[k] = 1000 + 97 * k;
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_x = 32'(vals[acc]);
      if (!in_ready) break;
      acc++;
      step();
    end
    checks++;
    if (acc !== 9) begin failures++; $display("FAIL stall_fill_count got=%0d exp=9", acc); end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || q_out !== 28'(vals[0] / 23)) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d in_ready=%0b valid=%0b q=%0d exp 0/1/%0d", c, in_ready, out_valid, q_out, vals[0] / 23);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) begin
        if (got < 10) begin
          checks++;
          if (q_out !== 28'(vals[got] / 23)) begin failures++; $display("FAIL stall_drain idx=%0d got=%0d exp=%0d", got, q_out, vals[got] / 23); end
        end
        got++;
      end
      step();
    end
    checks++;
    if (got !== 9) begin failures++; $display("FAIL stall_drain_count got=%0d exp=9", got); end
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = 32'd500; step();
    in_valid = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_x = 32'(230 + k); step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || q_out !== 28'd21) begin failures++; $display("FAIL rstmid_pre valid=%0b q=%0d exp q=21", out_valid, q_out); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || q_out !== 28'd0) begin
      failures++;
      $display("FAIL rstmid_immediate valid=%0b in_ready=%0b q=%0d exp 0/1/0", out_valid, in_ready, q_out);
    end
    step();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL rstmid_ghost got=%0d exp=0", seen); end
  endtask

  task automatic test_random_w24();
    logic [23:0] sb [$];
    logic [23:0] x;
    logic        prev_hold;
    logic [21:0] prev_q;
    int          n;
    out_ready2 = 1'b1;
    in_valid2 = 1'b1; in_x2 = 24'd100; step();
    in_valid2 = 1'b0;
    n = 1;
    while (!out_valid2 && n < 30) begin step(); n++; end
    checks++;
    if (n !== 9 || q_out2 !== 22'd14) begin failures++; $display("FAIL w24_latency lat=%0d q=%0d exp lat=9 q=14", n, q_out2); end
    step();
    prev_hold = 1'b0;
    prev_q = '0;
    for (int c = 0; c < 10000; c++) begin
      in_valid2 = ($urandom_range(0, 3) != 0);
      in_x2 = (c == 0) ? 24'hFFFFFF : (c == 1) ? 24'd0 : 24'($urandom);
      out_ready2 = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_hold) begin
        checks++;
        if (out_valid2 !== 1'b1 || q_out2 !== prev_q) begin failures++; $display("FAIL w24_hold cyc=%0d valid=%0b q=%0d exp q=%0d", c, out_valid2, q_out2, prev_q); end
      end
      if (in_valid2 && in_ready2) sb.push_back(in_x2);
      if (out_valid2 && out_ready2) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL w24_spurious cyc=%0d q=%0d", c, q_out2);
        end else begin
          x = sb.pop_front();
          if (q_out2 !== 22'(x / 24'd7)) begin failures++; $display("FAIL w24_q x=%0d got=%0d exp=%0d", x, q_out2, x / 24'd7); end
`ifdef CONST_DIV_REM_OUT_EN
          checks++;
          if (r_out2 !== 3'(x % 24'd7)) begin failures++; $display("FAIL w24_r x=%0d got=%0d exp=%0d", x, r_out2, x % 24'd7); end
`endif
        end
      end
      prev_hold = out_valid2 && !out_ready2;
      prev_q = q_out2;
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    out_ready2 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid2) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL w24_drain_spurious q=%0d", q_out2);
        end else begin
          x = sb.pop_front();
          if (q_out2 !== 22'(x / 24'd7)) begin failures++; $display("FAIL w24_drain_q x=%0d got=%0d exp=%0d", x, q_out2, x / 24'd7); end
        end
      end
      step();
    end
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL w24_lost got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single(32'd100, 28'd4, 5'd8, "x100");
    test_single(32'hFFFFFFFF, 28'd186737708, 5'd11, "xmax");
    test_single(32'd0, 28'd0, 5'd0, "xzero");
    test_single(32'h80000000, 28'd93368854, 5'd6, "xmsb");
    test_back_to_back();
    test_bubble();
    test_stall();
    test_reset_mid();
    test_single(32'd1000, 28'd43, 5'd11, "after_rst");
    test_random_w24();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
